// File: rtl/retire_multi_if.sv
// rtl/retire_multi_if.sv - ROB head window, register/memory commit and status bundle for retire_multi
interface retire_multi_if #(
  parameter int WIDTH = 2,
  parameter int XLEN  = 32,
  parameter int RAW   = 5,
  parameter int TAGW  = 4,
  parameter int CNTW  = 32
);
  localparam int PW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0]      head_valid;
  logic [WIDTH-1:0]      head_ready;
  logic [WIDTH-1:0]      head_regwr;
  logic [WIDTH-1:0]      head_memwr;
  logic [WIDTH-1:0]      head_mispredict;
  logic [WIDTH*RAW-1:0]  head_rd;
  logic [WIDTH*XLEN-1:0] head_value;
  logic [WIDTH*TAGW-1:0] head_tag;
  logic                  st_ack;

  logic [WIDTH-1:0]      regwr;
  logic [WIDTH*RAW-1:0]  rd;
  logic [WIDTH*XLEN-1:0] value;
  logic [WIDTH-1:0]      retire_valid;
  logic [WIDTH*TAGW-1:0] retire_tag;
  logic [PW-1:0]         rob_pop;
  logic                  st_req;
  logic [TAGW-1:0]       st_tag;
  logic [XLEN-1:0]       st_data;
  logic                  flush;
  logic [CNTW-1:0]       retired_count;

  modport master (
    output head_valid, head_ready, head_regwr, head_memwr, head_mispredict,
    output head_rd, head_value, head_tag, st_ack,
    input  regwr, rd, value, retire_valid, retire_tag, rob_pop,
    input  st_req, st_tag, st_data, flush, retired_count
  );

  modport slave (
    input  head_valid, head_ready, head_regwr, head_memwr, head_mispredict,
    input  head_rd, head_value, head_tag, st_ack,
    output regwr, rd, value, retire_valid, retire_tag, rob_pop,
    output st_req, st_tag, st_data, flush, retired_count
  );
endinterface

// File: rtl/retire_multi.sv
// rtl/retire_multi.sv - in-order multi-slot commit stage with store handshake and mispredict flush
module retire_multi #(
  parameter int WIDTH = 2,
  parameter int XLEN  = 32,
  parameter int RAW   = 5,
  parameter int TAGW  = 4,
  parameter int CNTW  = 32
) (
  input  logic          clk,
  input  logic          reset,
  retire_multi_if.slave bus
);
  localparam int PW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_STORE_WAIT = 2'd1,
    S_FLUSH      = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [TAGW-1:0]   st_tag_q, st_tag_d;
  logic [XLEN-1:0]   st_data_q, st_data_d;
  logic [CNTW-1:0]   count_q, count_d;

  logic [WIDTH-1:0]      commit;
  logic                  blocked;
  logic [WIDTH-1:0]      regwr_c;
  logic [WIDTH*RAW-1:0]  rd_c;
  logic [WIDTH*XLEN-1:0] value_c;
  logic [WIDTH*TAGW-1:0] tag_c;
  logic [PW-1:0]         pop_c;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      st_tag_q  <= '0;
      st_data_q <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      st_tag_q  <= st_tag_d;
      st_data_q <= st_data_d;
      count_q   <= count_d;
    end
  end

  // Walk the head window oldest-first; the first slot that cannot commit,
  // a store, or a committing mispredict closes the prefix for this cycle.
  always_comb begin
    state_d   = state_q;
    st_tag_d  = st_tag_q;
    st_data_d = st_data_q;
    commit    = '0;
    blocked   = 1'b0;
    case (state_q)
      S_IDLE: begin
        for (int i = 0; i < WIDTH; i++) begin
          if (!blocked) begin
            if (!(bus.head_valid[i] && bus.head_ready[i])) begin
              blocked = 1'b1;
            end else if (bus.head_memwr[i]) begin
              blocked = 1'b1;
              if (i == 0) begin
                state_d   = S_STORE_WAIT;
                st_tag_d  = bus.head_tag[0 +: TAGW];
                st_data_d = bus.head_value[0 +: XLEN];
              end
            end else begin
              commit[i] = 1'b1;
              if (bus.head_mispredict[i]) begin
                blocked = 1'b1;
                state_d = S_FLUSH;
              end
            end
          end
        end
      end
      S_STORE_WAIT: begin
        if (bus.st_ack && bus.head_valid[0]) begin
          commit[0] = 1'b1;
          state_d   = S_IDLE;
        end
      end
      S_FLUSH: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Commit-side datapath; the store itself never writes the register file.
  always_comb begin
    regwr_c = '0;
    rd_c    = '0;
    value_c = '0;
    tag_c   = '0;
    pop_c   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (commit[i]) begin
        regwr_c[i]                = bus.head_regwr[i] && (state_q == S_IDLE);
        rd_c[i*RAW +: RAW]        = bus.head_rd[i*RAW +: RAW];
        value_c[i*XLEN +: XLEN]   = bus.head_value[i*XLEN +: XLEN];
        tag_c[i*TAGW +: TAGW]     = bus.head_tag[i*TAGW +: TAGW];
        pop_c                     = pop_c + PW'(1);
      end
    end
  end

  assign count_d = count_q + CNTW'(pop_c);

  assign bus.regwr         = regwr_c;
  assign bus.rd            = rd_c;
  assign bus.value         = value_c;
  assign bus.retire_valid  = commit;
  assign bus.retire_tag    = tag_c;
  assign bus.rob_pop       = pop_c;
  assign bus.st_req        = (state_q == S_STORE_WAIT);
  assign bus.st_tag        = st_tag_q;
  assign bus.st_data       = st_data_q;
  assign bus.flush         = (state_q == S_FLUSH);
  assign bus.retired_count = count_q;
endmodule

// File: tb/tb_retire_multi.sv
// tb/tb_retire_multi.sv - directed and random commit-stage checks against a prefix-count reference model
module tb_retire_multi;
  localparam int W  = 2;
  localparam int XL = 32;
  localparam int RA = 5;
  localparam int TW = 4;
  localparam int CW = 4;
  localparam int PW = $clog2(W + 1);

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  retire_multi_if #(.WIDTH(W), .XLEN(XL), .RAW(RA), .TAGW(TW), .CNTW(CW)) bus ();
  retire_multi #(.WIDTH(W), .XLEN(XL), .RAW(RA), .TAGW(TW), .CNTW(CW)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  // Head window contents, one entry per slot
  bit              v [W];
  bit              r [W];
  bit              rw[W];
  bit              mw[W];
  bit              mp[W];
  logic [RA-1:0]   rdv[W];
  logic [XL-1:0]   val[W];
  logic [TW-1:0]   tg [W];
  bit              ack;

  // Reference model: which phase the commit stage is in, plus the counter
  bit              m_store;
  bit              m_flush;
  int              m_count;
  logic [TW-1:0]   m_st_tag;
  logic [XL-1:0]   m_st_data;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_slots();
    for (int i = 0; i < W; i++) begin
      v[i] = 0; r[i] = 0; rw[i] = 0; mw[i] = 0; mp[i] = 0;
      rdv[i] = '0; val[i] = '0; tg[i] = '0;
    end
    ack = 0;
  endtask

  task automatic set_slot(input int i, input bit sv, input bit sr, input bit srw, input bit smw,
                          input bit smp, input int srd, input logic [XL-1:0] sval, input int stg);
    v[i] = sv; r[i] = sr; rw[i] = srw; mw[i] = smw; mp[i] = smp;
    rdv[i] = RA'(srd); val[i] = sval; tg[i] = TW'(stg);
  endtask

  task automatic apply();
    for (int i = 0; i < W; i++) begin
      bus.head_valid[i]              = v[i];
      bus.head_ready[i]              = r[i];
      bus.head_regwr[i]              = rw[i];
      bus.head_memwr[i]              = mw[i];
      bus.head_mispredict[i]         = mp[i];
      bus.head_rd[i*RA +: RA]        = rdv[i];
      bus.head_value[i*XL +: XL]     = val[i];
      bus.head_tag[i*TW +: TW]       = tg[i];
    end
    bus.st_ack = ack;
  endtask

  // Drive current slots, compare every output against the model, then clock once.
  task automatic step();
    int n;
    bit go_store, go_flush;
    logic [W-1:0]    e_rv, e_rw;
    logic [W*RA-1:0] e_rd;
    logic [W*XL-1:0] e_val;
    logic [W*TW-1:0] e_tag;
    apply();
    #1;
    n = 0; go_store = 0; go_flush = 0;
    if (m_flush) n = 0;
    else if (m_store) n = (ack && v[0]) ? 1 : 0;
    else begin
      for (int i = 0; i < W; i++) begin
        if (!(v[i] && r[i])) break;
        if (mw[i]) begin go_store = (i == 0); break; end
        n++;
        if (mp[i]) begin go_flush = 1; break; end
      end
    end
    e_rv = '0; e_rw = '0; e_rd = '0; e_val = '0; e_tag = '0;
    for (int i = 0; i < n; i++) begin
      e_rv[i] = 1'b1;
      e_rw[i] = rw[i] && !m_store;
      e_rd[i*RA +: RA]  = rdv[i];
      e_val[i*XL +: XL] = val[i];
      e_tag[i*TW +: TW] = tg[i];
    end
    check("retire_valid", 64'(bus.retire_valid), 64'(e_rv));
    check("regwr", 64'(bus.regwr), 64'(e_rw));
    check("rd", 64'(bus.rd), 64'(e_rd));
    check("value", 64'(bus.value), 64'(e_val));
    check("retire_tag", 64'(bus.retire_tag), 64'(e_tag));
    check("rob_pop", 64'(bus.rob_pop), 64'(n));
    check("st_req", 64'(bus.st_req), 64'(m_store));
    check("flush", 64'(bus.flush), 64'(m_flush));
    check("retired_count", 64'(bus.retired_count), 64'(m_count));
    if (m_store) begin
      check("st_tag", 64'(bus.st_tag), 64'(m_st_tag));
      check("st_data", 64'(bus.st_data), 64'(m_st_data));
    end
    @(posedge clk);
    m_count = (m_count + n) % (1 << CW);
    if (m_flush) m_flush = 0;
    else if (m_store) begin
      if (n == 1) m_store = 0;
    end else if (go_store) begin
      m_store = 1; m_st_tag = tg[0]; m_st_data = val[0];
    end else if (go_flush) m_flush = 1;
    @(negedge clk);
  endtask

  task automatic model_reset();
    m_store = 0; m_flush = 0; m_count = 0; m_st_tag = '0; m_st_data = '0;
  endtask

  initial begin
    clear_slots();
    apply();
    model_reset();
    reset = 1'b1;
    #2;
    check("reset_rob_pop", 64'(bus.rob_pop), 64'(0));
    check("reset_st_req", 64'(bus.st_req), 64'(0));
    check("reset_flush", 64'(bus.flush), 64'(0));
    check("reset_count", 64'(bus.retired_count), 64'(0));
    check("reset_retire_valid", 64'(bus.retire_valid), 64'(0));
    @(negedge clk);
    reset = 1'b0;

    // Single retire makes the count odd so the double-retire run wraps 15 -> 1
    set_slot(0, 1, 1, 1, 0, 0, 3, 32'hA, 1);
    step();
    set_slot(0, 1, 1, 1, 0, 0, 3, 32'hA, 2);
    set_slot(1, 1, 1, 1, 0, 0, 7, 32'hB, 3);
    for (int k = 0; k < 9; k++) step();

    // Strict prefix: an unready oldest slot blocks a ready younger one
    set_slot(0, 1, 0, 1, 0, 0, 4, 32'h11, 4);
    set_slot(1, 1, 1, 1, 0, 0, 5, 32'h22, 5);
    step();
    r[0] = 1;
    step();

    // Store at slot 1, then at slot 0 with a delayed acknowledge
    set_slot(0, 1, 1, 1, 0, 0, 6, 32'h33, 6);
    set_slot(1, 1, 1, 0, 1, 0, 0, 32'hDEAD_BEEF, 7);
    step();
    set_slot(0, 1, 1, 1, 1, 0, 9, 32'hDEAD_BEEF, 7);
    set_slot(1, 1, 1, 1, 0, 0, 8, 32'h44, 8);
    step();
    for (int k = 0; k < 3; k++) step();
    ack = 1;
    step();
    ack = 0;
    clear_slots();
    step();

    // Mispredict at slot 0 blocks slot 1 and opens one flush bubble
    set_slot(0, 1, 1, 1, 0, 1, 10, 32'h55, 9);
    set_slot(1, 1, 1, 1, 0, 0, 11, 32'h66, 10);
    step();
    mp[0] = 0;
    step();
    step();

    // Acknowledge outside STORE_WAIT is ignored
    clear_slots();
    ack = 1;
    step();
    set_slot(0, 1, 1, 0, 0, 0, 1, 32'h77, 11);
    step();
    ack = 0;

    // Asynchronous reset in the middle of a store handshake
    clear_slots();
    set_slot(0, 1, 1, 0, 1, 0, 0, 32'hCAFE_F00D, 12);
    step();
    step();
    reset = 1'b1;
    #1;
    model_reset();
    check("async_rst_st_req", 64'(bus.st_req), 64'(0));
    check("async_rst_count", 64'(bus.retired_count), 64'(0));
    check("async_rst_flush", 64'(bus.flush), 64'(0));
    @(negedge clk);
    reset = 1'b0;
    clear_slots();
    step();

    // Random traffic; a pending store stays parked at slot 0
    for (int k = 0; k < 300; k++) begin
      for (int i = 0; i < W; i++) begin
        set_slot(i, $urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0,
                 int'($urandom_range(0, 31)), $urandom, int'($urandom_range(0, 15)));
      end
      if (m_store) begin
        v[0] = 1; mw[0] = 1; tg[0] = m_st_tag; val[0] = m_st_data;
      end
      ack = $urandom_range(0, 2) == 0;
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/retire_multi.md
Name: retire_multi

Overview:
- Parametrised in-order commit stage for the P6-style out-of-order core. Sits between the ROB head window and the architectural register file, map table and data memory.
- Retires up to WIDTH ready entries per cycle from the oldest ROB slots.
- Serialises stores through a request/acknowledge handshake with memory.
- Raises a one-cycle flush when a mispredicted branch commits.
- Keeps a running count of retired instructions.

Parameters:
- WIDTH, 2: number of ROB head slots examined, and the maximum retires per cycle (1..4).
- XLEN, 32: data value width.
- RAW, 5: architectural register index width.
- TAGW, 4: ROB tag width.
- CNTW, 32: retired-instruction counter width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- head_valid  in  WIDTH  slot i holds a live ROB entry; slot 0 is oldest.
- head_ready  in  WIDTH  slot i result is complete.
- head_regwr  in  WIDTH  slot i writes a register.
- head_memwr  in  WIDTH  slot i is a store.
- head_mispredict  in  WIDTH  slot i is a mispredicted branch.
- head_rd  in  WIDTH*RAW  destination register per slot.
- head_value  in  WIDTH*XLEN  result or store data per slot.
- head_tag  in  WIDTH*TAGW  ROB tag per slot.
- st_ack  in  1  memory has accepted the pending store.
- regwr  out  WIDTH  register-file write enable per slot.
- rd  out  WIDTH*RAW  write index per slot.
- value  out  WIDTH*XLEN  write data per slot.
- retire_valid  out  WIDTH  slot i commits this cycle; used for the map-table clear.
- retire_tag  out  WIDTH*TAGW  tag of each committing slot.
- rob_pop  out  $clog2(WIDTH+1)  number of entries the ROB removes this cycle.
- st_req  out  1  store request, held until acknowledged.
- st_tag  out  TAGW  tag of the pending store.
- st_data  out  XLEN  data of the pending store.
- flush  out  1  registered one-cycle pipeline-flush pulse.
- retired_count  out  CNTW  total instructions committed.

Behaviour:
- Reset: state IDLE. All outputs 0. retired_count 0. Reset asserted mid-STORE_WAIT or mid-FLUSH drops st_req and flush immediately.
- States:
  - IDLE: normal retirement.
  - STORE_WAIT: handshake for the store at slot 0.
  - FLUSH: single bubble cycle.
- Commit eligibility in IDLE: slot i is eligible when head_valid[i] and head_ready[i] are both 1 and every slot j<i commits this cycle. This is a strict prefix; no holes.
- Store at slot k in IDLE:
  - Slots below k commit; slot k and all younger slots do not.
  - If k==0 and the slot is ready, go to STORE_WAIT next cycle and capture st_tag/st_data.
- Mispredicting non-store at slot k:
  - Slot k commits; younger slots are blocked that cycle.
  - Go to FLUSH.
  - flush is 1 during the FLUSH cycle only.
  - In FLUSH, nothing commits and retire_valid is 0.
  - Then return to IDLE.
- head_mispredict on a store is ignored; the store rule takes precedence.
- STORE_WAIT:
  - st_req=1, with st_tag/st_data stable.
  - No other slot commits.
  - In the cycle st_ack=1: retire_valid[0]=1, rob_pop=1, regwr[0]=0, and the state returns to IDLE.
  - st_req falls the next cycle.
  - st_ack while not in STORE_WAIT is ignored.
- Output timing:
  - regwr, rd, value, retire_valid, retire_tag and rob_pop are combinational from the head inputs and the current state. Retirement is zero-latency from ready.
  - regwr[i] = retire_valid[i] AND head_regwr[i].
  - rd and value are zero for non-committing slots.
- Counts:
  - rob_pop = popcount(retire_valid).
  - retired_count += rob_pop at each clock edge, wrapping modulo 2^CNTW.
- head_valid=0 at slot 0: rob_pop=0 and the state is held.

Test Plan:
- Pop-count wrap: WIDTH=2; both slots ready, regwr=1, rd=3/7, value=0xA/0xB -> regwr=2'b11, rob_pop=2, count +2 per cycle; the count wraps from 2^CNTW-1 to 1.
- Strict prefix: slot0 not ready, slot1 ready -> retire_valid=0, rob_pop=0; slot0 ready next cycle -> both commit.
- Store at slot 1:
  - Cycle 0: slot0 ALU ready, slot1 store -> slot0 only commits.
  - Next cycle (store now at slot 0): enter STORE_WAIT; st_req=1, st_tag equals the store tag.
  - st_ack held 0 for 3 cycles -> no commits during that time.
  - st_ack=1 -> rob_pop=1, regwr[0]=0; st_req=0 the following cycle.
- Mispredict at slot 0 with slot 1 ready -> only slot 0 commits; flush=1 exactly one cycle later; zero commits in that cycle; IDLE after.
- Async reset asserted during STORE_WAIT -> st_req=0 and retired_count=0 immediately; IDLE on release.
- st_ack pulse while in IDLE -> no effect on rob_pop or state.
